// File: rtl/serial_addsub_if.sv
// Request/result handshake bundle for serial_addsub: operand request channel
// (in_valid/in_ready) and result channel (out_valid/out_ready).
interface serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, r, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, r, c_out, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock, LSB first.
// Define ADDSUB_SAT_EN to saturate r to the signed limit on overflow.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             sign_a_reg, sign_a_next;
    logic             sign_b_reg, sign_b_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             c_out_reg, c_out_next;
    logic             ovf_reg, ovf_next;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] res_shift;
    logic             last_digit;
    logic             ovf_calc;

    // One DIGIT-wide ripple chain fed by the carry registered from the previous digit.
    assign chain[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign dsum[gi]      = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
            assign chain[gi + 1] = (a_reg[gi] & b_reg[gi]) | (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
        end
    endgenerate

    // Result shift register holds the N-1 completed digits; the current digit enters at the top.
    generate
        if (N > 1) begin : g_res
            logic [WIDTH-DIGIT-1:0] res_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_reg <= '0;
                end else if (state_reg == RUN) begin
                    res_reg <= res_shift[WIDTH-1:DIGIT];
                end
            end
            assign res_shift = {dsum, res_reg};
        end else begin : g_res_single
            assign res_shift = dsum;
        end
    endgenerate

    assign last_digit = (cnt_reg == CW'(N - 1));
    assign ovf_calc   = (sign_a_reg == sign_b_reg) && (dsum[DIGIT-1] != sign_a_reg);

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;
        r_next      = r_reg;
        c_out_next  = c_out_reg;
        ovf_next    = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next      = bus.a;
                    b_next      = bus.sub ? ~bus.b : bus.b;
                    sign_a_next = bus.a[WIDTH-1];
                    sign_b_next = bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                    carry_next  = bus.sub;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                a_next     = a_reg >> DIGIT;
                b_next     = b_reg >> DIGIT;
                carry_next = chain[DIGIT];
                cnt_next   = cnt_reg + 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                    c_out_next = chain[DIGIT];
                    ovf_next   = ovf_calc;
`ifdef ADDSUB_SAT_EN
                    if (ovf_calc) begin
                        r_next = sign_a_reg ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
                    end else begin
                        r_next = res_shift;
                    end
`else
                    r_next = res_shift;
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            r_reg      <= '0;
            c_out_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            r_reg      <= r_next;
            c_out_reg  <= c_out_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Handshake outputs depend on state only.
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.r         = r_reg;
    assign bus.c_out     = c_out_reg;
    assign bus.ovf       = ovf_reg;
endmodule
